stage_if_buffered: RTL and testbench

- Parametrised next-generation instruction-fetch stage.
- Owns the fetch PC and issues requests to instruction memory over a valid/ready request channel with in-order responses.
- Tolerates up to MAX_OUTSTANDING in-flight requests and buffers returned words in a FIFO_DEPTH-entry instruction buffer.
- Presents words to decode over a valid/ready handshake; on a branch or jump redirect it flushes the buffer and discards stale in-flight responses.

---
 rtl/if_pkg.sv | 29 ++
 rtl/fifo_sync.sv | 78 +++++++
 rtl/stage_if_buffered.sv | 147 ++++++++++++++
 tb/tb_stage_if_buffered.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared fetch-stage types, encodings and sizing helpers.
package if_pkg;

    localparam int unsigned IF_ADDR_W      = 64;
    localparam int unsigned IF_INST_W      = 32;
    localparam int unsigned IF_PC_TYPE_NUM = 4;
    localparam int unsigned IF_PC_SEL_W    = 2;

    // Next-PC source select; any nonzero value is a redirect.
    typedef enum logic [IF_PC_SEL_W-1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_sel_e;

    // Instruction-buffer entry at the default widths.
    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_ADDR_W-1:0] pc4;
        logic [IF_INST_W-1:0] inst;
    } if_entry_t;

    // Pointer width for a FIFO of the given depth (never zero).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush; shared by all pipeline buffers.
module fifo_sync
    import if_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: flush wins, then guarded push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/stage_if_buffered.sv
// Instruction-fetch stage: owns the fetch PC, keeps up to MAX_OUTSTANDING
// requests in flight and buffers returned words for decode.
module stage_if_buffered
    import if_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = IF_ADDR_W,
    parameter int unsigned           INST_WIDTH      = IF_INST_W,
    parameter int unsigned           PC_TYPE_NUM     = IF_PC_TYPE_NUM,
    parameter int unsigned           FIFO_DEPTH      = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [$clog2(PC_TYPE_NUM)-1:0]    pc_sel,
    input  logic [ADDR_WIDTH-1:0]             bra_addr,
    input  logic [ADDR_WIDTH-1:0]             jal_addr,
    input  logic [ADDR_WIDTH-1:0]             jar_addr,
    output logic                              imem_req_valid,
    input  logic                              imem_req_ready,
    output logic [ADDR_WIDTH-1:0]             imem_req_addr,
    input  logic                              imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]             imem_rsp_data,
    output logic                              d_valid,
    input  logic                              d_ready,
    output logic [ADDR_WIDTH-1:0]             d_pc,
    output logic [ADDR_WIDTH-1:0]             d_pc4,
    output logic [INST_WIDTH-1:0]             d_inst_word,
    output logic                              inst_buffer_empty,
    output logic                              inst_buffer_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   inst_buffer_count
);

    localparam int unsigned SEL_W = $clog2(PC_TYPE_NUM);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pc4;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0]      discard_q, discard_d;
    logic [OUT_W-1:0]      outstanding;
    logic [ADDR_WIDTH-1:0] pend_pc;
    logic                  pend_empty, pend_full;
    entry_t                ibuf_din, ibuf_head;
    logic                  ibuf_empty, ibuf_full;
    logic [CNT_W-1:0]      ibuf_count;
    logic                  redirect_c, accept_c, rsp_c, ibuf_push_c, ibuf_pop_c;
    logic [ADDR_WIDTH-1:0] target_c;

    // Redirect target select.
    always_comb begin
        redirect_c = (pc_sel != '0);
        target_c   = fetch_pc_q;
        case (pc_sel)
            SEL_W'(PC_BRANCH): target_c = bra_addr;
            SEL_W'(PC_JAL):    target_c = jal_addr;
            SEL_W'(PC_JALR):   target_c = jar_addr;
            default:           target_c = fetch_pc_q;
        endcase
    end

    // Request issue: credit check keeps a buffer slot for every in-flight word.
    always_comb begin
        imem_req_valid = reset && !redirect_c && !pend_full
                         && ((32'(outstanding) + 32'(ibuf_count)) < FIFO_DEPTH);
        imem_req_addr  = fetch_pc_q;
        accept_c       = imem_req_valid && imem_req_ready;
    end

    // Fetch PC, discard counter and buffer push/pop decisions.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        discard_d   = discard_q;
        ibuf_push_c = 1'b0;
        rsp_c       = imem_rsp_valid && !pend_empty;
        ibuf_pop_c  = !ibuf_empty && d_ready && !redirect_c;
        ibuf_din    = '{pc: pend_pc, pc4: pend_pc + ADDR_WIDTH'(4), inst: imem_rsp_data};
        if (redirect_c) begin
            fetch_pc_d = target_c;
            discard_d  = outstanding - OUT_W'(rsp_c);
        end else begin
            if (accept_c) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            end
            if (rsp_c) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - OUT_W'(1);
                end else begin
                    ibuf_push_c = 1'b1;
                end
            end
        end
    end

    // Stage state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    // PCs of accepted requests, popped one per response; occupancy is the outstanding count.
    fifo_sync #(.WIDTH(ADDR_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_pend (
        .clk   (clk),
        .rst_n (reset),
        .push  (accept_c),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .din   (fetch_pc_q),
        .dout  (pend_pc),
        .count (outstanding),
        .empty (pend_empty),
        .full  (pend_full)
    );

    // Instruction buffer feeding decode; flushed on redirect.
    fifo_sync #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk   (clk),
        .rst_n (reset),
        .push  (ibuf_push_c),
        .pop   (ibuf_pop_c),
        .flush (redirect_c),
        .din   (ibuf_din),
        .dout  (ibuf_head),
        .count (ibuf_count),
        .empty (ibuf_empty),
        .full  (ibuf_full)
    );

    assign d_valid           = !ibuf_empty;
    assign d_pc              = ibuf_empty ? '0 : ibuf_head.pc;
    assign d_pc4             = ibuf_empty ? '0 : ibuf_head.pc4;
    assign d_inst_word       = ibuf_empty ? '0 : ibuf_head.inst;
    assign inst_buffer_empty = ibuf_empty;
    assign inst_buffer_full  = ibuf_full;
    assign inst_buffer_count = ibuf_count;

endmodule

// File: tb/tb_stage_if_buffered.sv
// Scoreboard bench for the buffered fetch stage with a latency-programmable memory model.
module tb_stage_if_buffered;

    localparam int unsigned AW = 64;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    pc_sel;
    logic [AW-1:0] bra_addr, jal_addr, jar_addr;
    logic          imem_req_valid, imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          d_valid, d_ready;
    logic [AW-1:0] d_pc, d_pc4;
    logic [IW-1:0] d_inst_word;
    logic          inst_buffer_empty, inst_buffer_full;
    logic [2:0]    inst_buffer_count;

    stage_if_buffered #(
        .ADDR_WIDTH(64), .INST_WIDTH(32), .PC_TYPE_NUM(4),
        .FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(64'h1000)
    ) dut (
        .clk(clk), .reset(reset), .pc_sel(pc_sel),
        .bra_addr(bra_addr), .jal_addr(jal_addr), .jar_addr(jar_addr),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .d_valid(d_valid), .d_ready(d_ready),
        .d_pc(d_pc), .d_pc4(d_pc4), .d_inst_word(d_inst_word),
        .inst_buffer_empty(inst_buffer_empty), .inst_buffer_full(inst_buffer_full),
        .inst_buffer_count(inst_buffer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mreq_t;

    mreq_t         mq[$];
    logic [AW-1:0] exp_q[$];
    int            pop_idx[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            neg_idx = 0;
    int            n_pop = 0;
    int            first_acc = -1;
    int            lat = 1;
    bit            stall = 1'b0;
    logic [AW-1:0] last_acc = '0;

    function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, neg_idx);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int c = 0;
        while (n_pop < target && c < budget) begin
            tick();
            c++;
        end
        check(name, 64'(n_pop), 64'(target));
    endtask

    // Memory model: in-order responses 'lat' cycles after acceptance.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b0;
        forever begin
            @(negedge clk);
            neg_idx++;
            imem_rsp_valid = 1'b0;
            if (reset && mq.size() > 0 && mq[0].due <= neg_idx) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = inst_of(mq[0].addr);
                void'(mq.pop_front());
            end
            #2;
            imem_req_ready = !stall;
            if (!reset) begin
                mq.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{addr: imem_req_addr, due: neg_idx + lat});
                last_acc = imem_req_addr;
                if (first_acc < 0) first_acc = neg_idx;
            end
        end
    end

    // Monitor: compare each word decode takes against the scoreboard.
    initial begin
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (reset && imem_rsp_valid && dut.outstanding == '0) begin
                n_fail++;
                $display("FAIL rsp_without_request: response with outstanding 0 at cycle %0d", neg_idx);
            end
            if (reset && pc_sel == 2'd0 && d_valid && d_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got pc 0x%0h expected none", d_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("d_pc", d_pc, e);
                    check("d_pc4", d_pc4, e + 64'd4);
                    check("d_inst", 64'(d_inst_word), 64'(inst_of(e)));
                end
                n_pop++;
                pop_idx.push_back(neg_idx);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed scenarios.
    initial begin
        int c, first_dv, base, exp_disc;
        bit found;
        logic [AW-1:0] addr_exp;

        reset = 1'b0; pc_sel = 2'd0; d_ready = 1'b0;
        bra_addr = '0; jal_addr = '0; jar_addr = '0;
        tick(); tick();

        // Reset state
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_empty", 64'(inst_buffer_empty), 64'd1);
        check("rst_full", 64'(inst_buffer_full), 64'd0);
        check("rst_count", 64'(inst_buffer_count), 64'd0);
        check("rst_d_pc", d_pc, 64'd0);
        check("rst_d_pc4", d_pc4, 64'd0);
        check("rst_d_inst", 64'(d_inst_word), 64'd0);
        check("rst_req_addr", imem_req_addr, 64'h1000);

        // Free run, 1-cycle memory
        push_stream(64'h1000, 64);
        first_acc = -1; lat = 1; d_ready = 1'b1; reset = 1'b1;
        first_dv = -1; c = 0;
        while (c < 20) begin
            tick(); c++;
            if (d_valid) begin first_dv = neg_idx; break; end
        end
        check("first_valid_latency", 64'(first_dv), 64'(first_acc + 2));
        wait_pops(8, 40, "freerun_pops");
        if (pop_idx.size() >= 8) check("throughput", 64'(pop_idx[7] - pop_idx[0]), 64'd7);
        else check("throughput_pops", 64'(pop_idx.size()), 64'd8);

        // Decode stall fills buffer to capacity
        d_ready = 1'b0;
        repeat (10) tick();
        check("stall_full", 64'(inst_buffer_full), 64'd1);
        check("stall_count", 64'(inst_buffer_count), 64'd4);
        check("stall_req_valid", 64'(imem_req_valid), 64'd0);
        check("stall_d_valid", 64'(d_valid), 64'd1);
        d_ready = 1'b1;
        wait_pops(24, 60, "stall_release_pops");

        // Redirect with two responses in flight (latency 3)
        lat = 3; found = 1'b0; c = 0;
        while (c < 50) begin
            tick(); c++;
            if (mq.size() == 2 && !imem_rsp_valid) begin found = 1'b1; break; end
        end
        check("c_setup", 64'(found), 64'd1);
        bra_addr = 64'h2000; pc_sel = 2'd1;
        exp_q.delete(); push_stream(64'h2000, 32);
        tick();
        pc_sel = 2'd0;
        check("c_count", 64'(inst_buffer_count), 64'd0);
        check("c_empty", 64'(inst_buffer_empty), 64'd1);
        check("c_discard", 64'(dut.discard_q), 64'd2);
        check("c_req_addr", imem_req_addr, 64'h2000);
        base = n_pop;
        wait_pops(base + 6, 80, "c_pops");

        // Drain, then redirect in a cycle with a response and a decode pop
        stall = 1'b1; found = 1'b0; c = 0;
        while (c < 40) begin
            tick(); c++;
            if (mq.size() == 0 && !imem_rsp_valid && inst_buffer_empty) begin found = 1'b1; break; end
        end
        check("d_drain", 64'(found), 64'd1);
        stall = 1'b0; d_ready = 1'b0; lat = 2; found = 1'b0; c = 0;
        while (c < 20) begin
            tick(); c++;
            if (imem_rsp_valid && d_valid && mq.size() == 1) begin found = 1'b1; break; end
        end
        check("d_setup", 64'(found), 64'd1);
        exp_disc = mq.size();
        d_ready = 1'b1; bra_addr = 64'h2800; pc_sel = 2'd1;
        exp_q.delete(); push_stream(64'h2800, 32);
        tick();
        pc_sel = 2'd0;
        check("d_count", 64'(inst_buffer_count), 64'd0);
        check("d_discard", 64'(dut.discard_q), 64'(exp_disc));
        check("d_discard_abs", 64'(dut.discard_q), 64'd1);
        base = n_pop;
        wait_pops(base + 4, 60, "d_pops");

        // Back-to-back redirects: second target wins
        lat = 1; jal_addr = 64'h3000; pc_sel = 2'd2;
        exp_q.delete(); push_stream(64'h4000, 32);
        tick();
        jar_addr = 64'h4000; pc_sel = 2'd3;
        check("e_req_valid_redirect", 64'(imem_req_valid), 64'd0);
        tick();
        pc_sel = 2'd0;
        check("e_count", 64'(inst_buffer_count), 64'd0);
        check("e_req_addr", imem_req_addr, 64'h4000);
        base = n_pop;
        wait_pops(base + 4, 40, "e_pops");

        // Memory stall, then reset mid-stall
        stall = 1'b1;
        addr_exp = last_acc + 64'd4;
        check("f_addr_start", imem_req_addr, addr_exp);
        repeat (5) begin
            tick();
            check("f_addr_hold", imem_req_addr, addr_exp);
        end
        reset = 1'b0;
        exp_q.delete(); push_stream(64'h1000, 32);
        tick();
        reset = 1'b1; stall = 1'b0;
        check("f_count", 64'(inst_buffer_count), 64'd0);
        check("f_empty", 64'(inst_buffer_empty), 64'd1);
        check("f_d_valid", 64'(d_valid), 64'd0);
        check("f_req_addr", imem_req_addr, 64'h1000);
        base = n_pop;
        wait_pops(base + 4, 40, "f_pops");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
